// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter
// Round-robin arbiter that shares the single L2 request port among several
// upstream request queues. The winning packet is captured into a one-entry
// output register that holds steady while the L2 applies backpressure.

package l2_request_arbiter_pkg;

   // Request packet handed to the L2 pipeline. The arbiter never looks at
   // anything except .valid; all other fields pass through untouched.
   typedef struct packed {
      logic        valid;
      logic [1:0]  req_type;
      logic [2:0]  core_id;
      logic [39:0] addr;
      logic [31:0] wdata;
   } l2req_packet_t;

endpackage

module l2_request_arbiter
   import l2_request_arbiter_pkg::*;
#(
   parameter int NUM_REQUESTERS = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  l2req_packet_t [NUM_REQUESTERS-1:0]  req_packet,
   output logic          [NUM_REQUESTERS-1:0]  req_ready,
   output l2req_packet_t                       l2req_packet,
   input  logic                                l2req_ready,
   output logic                                pc_event_arb_conflict
);

   // NUM_REQUESTERS is 2..8, so the pointer is always at least one bit wide.
   localparam int PTR_W  = $clog2(NUM_REQUESTERS);
   // One extra bit so rr_ptr + offset can be formed before the modulo wrap.
   localparam int CAND_W = PTR_W + 1;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t               state_reg;
   state_t               state_next;
   l2req_packet_t        pkt_reg;
   l2req_packet_t        pkt_next;
   logic [PTR_W-1:0]     rr_ptr_reg;
   logic [PTR_W-1:0]     rr_ptr_next;

   logic [NUM_REQUESTERS-1:0] req_valid;
   logic                      can_load;
   logic                      any_valid;
   logic                      grant;
   logic [PTR_W-1:0]          grant_idx;
   logic [CAND_W-1:0]         cand;

   // Gather the per-requester valid bits into a flat vector.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_valid
         assign req_valid[gi] = req_packet[gi].valid;
      end
   endgenerate

   // The register may take a new packet when it is empty or when its current
   // packet is leaving this cycle; this is what lets l2req_ready reach
   // req_ready combinationally for full throughput.
   assign can_load  = (state_reg == ST_EMPTY) || l2req_ready;
   assign any_valid = |req_valid;
   assign grant     = can_load && any_valid && !reset;

   // Round-robin search: scan offsets from highest to lowest so that the valid
   // requester closest to rr_ptr (offset 0 first) is the last, winning write.
   always_comb begin
      grant_idx = '0;
      cand      = '0;
      for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_reg} + CAND_W'(k);
         if (cand >= CAND_W'(NUM_REQUESTERS)) begin
            cand = cand - CAND_W'(NUM_REQUESTERS);
         end
         if (req_valid[cand[PTR_W-1:0]]) begin
            grant_idx = cand[PTR_W-1:0];
         end
      end
   end

   // One-hot grant, only ever on a requester that is actually valid.
   generate
      for (gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_ready
         assign req_ready[gi] = grant && (grant_idx == PTR_W'(gi));
      end
   endgenerate

   // Contention counter event: a grant issued while others were also waiting.
   assign pc_event_arb_conflict = grant && ($countones(req_valid) >= 2);

   // Next-state logic for the output register and the priority pointer.
   always_comb begin
      state_next  = state_reg;
      pkt_next    = pkt_reg;
      rr_ptr_next = rr_ptr_reg;
      if (grant) begin
         // New packet loads, either into an empty slot or back-to-back behind
         // the one the L2 is accepting this cycle.
         state_next  = ST_FULL;
         pkt_next    = req_packet[grant_idx];
         rr_ptr_next = (grant_idx == PTR_W'(NUM_REQUESTERS - 1)) ? '0
                                                                  : grant_idx + PTR_W'(1);
      end else if ((state_reg == ST_FULL) && l2req_ready) begin
         // Packet consumed with nothing to replace it: drop valid only.
         state_next     = ST_EMPTY;
         pkt_next.valid = 1'b0;
      end
      // FULL without l2req_ready: everything holds bit-exact by default.
   end

   // State, packet and pointer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_EMPTY;
         pkt_reg    <= '0;
         rr_ptr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         pkt_reg    <= pkt_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // The output comes straight from the register; l2req_ready never reaches it.
   assign l2req_packet = pkt_reg;

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Testbench for l2_request_arbiter: a per-cycle driver with a behavioural
// reference model, and a separate monitor that checks every packet presented
// to the L2 against a scoreboard queue.
module tb_l2_request_arbiter;
   import l2_request_arbiter_pkg::*;

   localparam int N = 4;

   logic                     clk = 1'b0;
   logic                     reset;
   l2req_packet_t [N-1:0]    req_packet;
   logic [N-1:0]             req_ready;
   l2req_packet_t            l2req_packet;
   logic                     l2req_ready;
   logic                     pc_event_arb_conflict;

   always #5 clk = ~clk;

   l2_request_arbiter #(.NUM_REQUESTERS(N)) dut (
      .clk                   (clk),
      .reset                 (reset),
      .req_packet            (req_packet),
      .req_ready             (req_ready),
      .l2req_packet          (l2req_packet),
      .l2req_ready           (l2req_ready),
      .pc_event_arb_conflict (pc_event_arb_conflict)
   );

   int tests_run    = 0;
   int tests_failed = 0;
   bit done         = 1'b0;

   // Reference model state: which requesters hold an ungranted request,
   // whether the output slot is occupied, and the round-robin start index.
   logic [N-1:0]   pend;
   l2req_packet_t  pend_pkt [N];
   bit             m_full;
   int             m_rr;
   l2req_packet_t  sb_q [$];

   function automatic l2req_packet_t rand_pkt(input int idx, input bit v);
      l2req_packet_t p;
      p.valid    = v;
      p.req_type = 2'($urandom_range(0, 3));
      p.core_id  = 3'(idx);
      p.addr     = {8'($urandom), 32'($urandom)};
      p.wdata    = 32'($urandom);
      return p;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: requesters in 'offer' raise a new request if idle,
   // the model predicts this cycle's grant, and the model advances.
   task automatic cycle(input bit rst, input logic [N-1:0] offer, input bit l2r);
      int           g;
      logic [N-1:0] exp_ready;
      bit           exp_conf;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (offer[i] && !pend[i]) begin
            pend[i]     = 1'b1;
            pend_pkt[i] = rand_pkt(i, 1'b1);
         end
         req_packet[i] = pend[i] ? pend_pkt[i] : rand_pkt(i, 1'b0);
      end
      reset       = rst;
      l2req_ready = l2r;
      #1;
      g = -1;
      if (!rst && (!m_full || l2r)) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && pend[(m_rr + k) % N]) g = (m_rr + k) % N;
         end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      exp_conf = (g >= 0) && ($countones(pend) >= 2);
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("arb_conflict", 32'(pc_event_arb_conflict), 32'(exp_conf));
      check("out_valid", 32'(l2req_packet.valid), 32'(m_full));
      if (rst) begin
         m_full = 1'b0;
         m_rr   = 0;
         sb_q.delete();
      end else begin
         if (m_full && l2r) m_full = 1'b0;
         if (g >= 0) begin
            m_full = 1'b1;
            m_rr   = (g + 1) % N;
            sb_q.push_back(pend_pkt[g]);
            pend[g] = 1'b0;
         end
      end
   endtask

   // Monitor: whenever the DUT presents a packet, it must match the oldest
   // expected packet; it is retired once the L2 accepts it.
   initial begin
      while (!done) begin
         @(negedge clk);
         #2;
         if (!reset && l2req_packet.valid) begin
            tests_run++;
            if (sb_q.size() == 0) begin
               tests_failed++;
               $display("[TB] FAIL out_unexpected: got %h, required no packet", l2req_packet);
            end else begin
               if (l2req_packet !== sb_q[0]) begin
                  tests_failed++;
                  $display("[TB] FAIL out_packet: got %h, required %h", l2req_packet, sb_q[0]);
               end
               if (l2req_ready) begin
                  $display("[TB] accept core=%0d type=%0d addr=%h data=%h",
                           l2req_packet.core_id, l2req_packet.req_type,
                           l2req_packet.addr, l2req_packet.wdata);
                  void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic.
   initial begin
      reset       = 1'b1;
      l2req_ready = 1'b0;
      req_packet  = '0;
      pend        = '0;
      m_full      = 1'b0;
      m_rr        = 0;

      // Reset held with every requester valid, then round-robin streaming.
      cycle(1'b1, 4'b1111, 1'b1);
      cycle(1'b1, 4'b1111, 1'b1);
      repeat (8) cycle(1'b0, 4'b1111, 1'b1);
      repeat (5) cycle(1'b0, 4'b0000, 1'b1);

      // Backpressure with requester 2's packet held in the output register.
      cycle(1'b0, 4'b0100, 1'b1);
      repeat (5) cycle(1'b0, 4'b1111, 1'b0);
      cycle(1'b0, 4'b1111, 1'b1);
      repeat (6) cycle(1'b0, 4'b0000, 1'b1);

      // Sparse requests with pointer wrap, then everyone contends.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b1000, 1'b1);
      cycle(1'b0, 4'b0010, 1'b1);
      cycle(1'b0, 4'b1111, 1'b1);
      repeat (6) cycle(1'b0, 4'b0000, 1'b1);

      // Single packet drain; idle cycles must not move priority.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0001, 1'b1);
      repeat (3) cycle(1'b0, 4'b0000, 1'b1);
      cycle(1'b0, 4'b1111, 1'b1);
      repeat (6) cycle(1'b0, 4'b0000, 1'b1);

      // Reset while FULL under backpressure.
      cycle(1'b1, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0100, 1'b1);
      cycle(1'b0, 4'b0000, 1'b0);
      cycle(1'b1, 4'b1111, 1'b0);
      cycle(1'b0, 4'b1111, 1'b1);
      repeat (6) cycle(1'b0, 4'b0000, 1'b1);

      // Randomized traffic with random backpressure and occasional reset.
      for (int t = 0; t < 300; t++) begin
         cycle($urandom_range(0, 49) == 0, 4'($urandom),
               $urandom_range(0, 3) != 0);
      end
      repeat (8) cycle(1'b0, 4'b0000, 1'b1);

      #2;
      check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
      done = 1'b1;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
